// File: rtl/ram_write_buffer_if.sv
// ram_write_buffer_if: read/write bus between the cache controller and the backing RAM stage
interface ram_write_buffer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  ram_read_en;
  logic                  ram_write_en;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_write_data;
  logic [DATA_WIDTH-1:0] ram_read_data;
  logic                  rd_valid;
  modport master (
    output ram_read_en, ram_write_en, ram_address, ram_write_data,
    input  ram_read_data, rd_valid
  );
  modport slave (
    input  ram_read_en, ram_write_en, ram_address, ram_write_data,
    output ram_read_data, rd_valid
  );
endinterface

// File: rtl/ram_write_buffer.sv
// ram_write_buffer: main-memory array with a coalescing posted-write FIFO and forwarded 2-cycle reads
module ram_write_buffer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int WB_DEPTH   = 4,
  parameter int MEM_WORDS  = 2**(ADDR_WIDTH-2)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ram_write_buffer_if.slave           bus,
  input  logic                        flush_req,
  output logic                        flush_done,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        wb_empty
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [AW-1:0]         addr_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [WB_DEPTH];
  logic [WB_DEPTH-1:0]   vld_q, vld_d;
  logic [PW-1:0]         head_q, tail_q, hit_idx;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         wa;
  logic [DATA_WIDTH-1:0] wd, fwd_data_d, fwd_data_q, mem_rd_q, rd_data_q;
  logic                  re, we, hit, full, enq, coal, drain, fire;
  logic                  fwd_hit_d, fwd_hit_q, rd_pend_q, rd_valid_q, armed_q, flush_done_q;
  logic                  unused_addr_lsbs;

  assign re = bus.ram_read_en;
  assign we = bus.ram_write_en;
  assign wa = bus.ram_address[ADDR_WIDTH-1:2];
  assign wd = bus.ram_write_data;
  assign unused_addr_lsbs = ^bus.ram_address[1:0];

  // Associative lookup of the shared address against every valid entry; coalescing keeps matches unique
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < WB_DEPTH; i++)
      if (vld_q[i] && addr_q[i] == wa) begin
        hit = 1'b1;
        hit_idx = PW'(i);
      end
  end

  assign full  = count_q == CW'(WB_DEPTH);
  assign coal  = we & hit;
  assign enq   = we & ~hit;
  assign drain = (count_q != '0) & ((~re & ~we) | (enq & full) | (flush_req & ~we));
  assign count_d = count_q + CW'(enq) - CW'(drain);
  // A same-cycle write is youngest, so it wins over any buffered copy
  assign fwd_hit_d  = we | hit;
  assign fwd_data_d = we ? wd : data_q[hit_idx];
  assign fire = flush_req & armed_q & (count_q == '0);

  // Valid bits: retire the head, then claim the tail (same slot when forced-draining a full FIFO)
  always_comb begin
    vld_d = vld_q;
    if (drain) vld_d[head_q] = 1'b0;
    if (enq) vld_d[tail_q] = 1'b1;
  end

  // Array write/read ports and FIFO payload storage; none of these are reset
  always_ff @(posedge clk) begin
    if (drain) mem_q[addr_q[head_q]] <= data_q[head_q];
    if (enq) begin
      addr_q[tail_q] <= wa;
      data_q[tail_q] <= wd;
    end else if (coal) begin
      data_q[hit_idx] <= wd;
    end
    if (re) mem_rd_q <= mem_q[wa];
  end

  // FIFO control, two-stage read pipeline and flush handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      vld_q        <= '0;
      rd_pend_q    <= 1'b0;
      fwd_hit_q    <= 1'b0;
      fwd_data_q   <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      armed_q      <= 1'b1;
      flush_done_q <= 1'b0;
    end else begin
      head_q       <= head_q + PW'(drain);
      tail_q       <= tail_q + PW'(enq);
      count_q      <= count_d;
      vld_q        <= vld_d;
      rd_pend_q    <= re;
      fwd_hit_q    <= fwd_hit_d;
      fwd_data_q   <= fwd_data_d;
      rd_valid_q   <= rd_pend_q;
      if (rd_pend_q) rd_data_q <= fwd_hit_q ? fwd_data_q : mem_rd_q;
      flush_done_q <= fire;
      armed_q      <= ~flush_req | (armed_q & ~fire);
    end
  end

  assign bus.ram_read_data = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign flush_done        = flush_done_q;
  assign wb_count          = count_q;
  assign wb_empty          = count_q == '0;
endmodule

// File: tb/tb_ram_write_buffer.sv
// tb_ram_write_buffer: scoreboard bench for the posted-write RAM stage
module tb_ram_write_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_req = 1'b0;
  logic flush_done;
  logic [2:0] wb_count;
  logic wb_empty;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] mdl [logic [13:0]];
  logic [31:0] exp_q [$];
  int iss_q [$];

  ram_write_buffer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  ram_write_buffer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush_req(flush_req),
    .flush_done(flush_done), .wb_count(wb_count), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.ram_read_en  = 1'b0;
    bus.ram_write_en = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic io(bit re, bit we, logic [15:0] a, logic [31:0] d);
    bus.ram_read_en    = re;
    bus.ram_write_en   = we;
    bus.ram_address    = a;
    bus.ram_write_data = d;
    if (we) mdl[a[15:2]] = d;
    if (re) begin
      exp_q.push_back(mdl[a[15:2]]);
      iss_q.push_back(cyc);
    end
    step();
  endtask

  always @(negedge clk)
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) chk("rd_spurious", 32'd1, 32'd0);
      else begin
        chk("rd_data", bus.ram_read_data, exp_q.pop_front());
        chk("rd_latency", cyc - iss_q.pop_front(), 32'd2);
      end
    end

  initial begin
    logic [31:0] cnt_exp [5] = '{2, 1, 0, 0, 0};
    logic [31:0] fd_exp  [5] = '{0, 0, 0, 1, 0};
    logic [15:0] wa4 [5] = '{16'h1000, 16'h1004, 16'h1008, 16'h100C, 16'h1010};
    bus.ram_read_en = 1'b0;
    bus.ram_write_en = 1'b0;
    bus.ram_address = '0;
    bus.ram_write_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.ram_read_data, 0);
    chk("rst_count", wb_count, 0);
    chk("rst_empty", wb_empty, 1);
    chk("rst_flush_done", flush_done, 0);
    rst_n = 1'b1;
    idle(1);
    // Preload the array, then read from it
    io(0, 1, 16'h0040, 32'h11111111);
    chk("pre_count", wb_count, 1);
    idle(1);
    chk("pre_empty", wb_empty, 1);
    chk("pre_backdoor", dut.mem_q[14'h010], 32'h11111111);
    io(1, 0, 16'h0040, 32'h0);
    chk("arr_rd_empty0", wb_empty, 1);
    idle(1);
    chk("arr_rd_empty1", wb_empty, 1);
    idle(2);
    // Store-to-load forwarding
    io(0, 1, 16'h0100, 32'hDEADBEEF);
    chk("fwd_count", wb_count, 1);
    io(1, 0, 16'h0100, 32'h0);
    chk("fwd_count_after", wb_count, 1);
    idle(4);
    // Coalescing
    io(0, 1, 16'h0200, 32'hA0A0A0A0);
    io(0, 1, 16'h0202, 32'hB0B0B0B0);
    chk("coal_count", wb_count, 1);
    idle(2);
    chk("coal_backdoor", dut.mem_q[14'h080], 32'hB0B0B0B0);
    io(1, 0, 16'h0200, 32'h0);
    idle(3);
    // Fill the FIFO, then force a drain with a fifth write
    for (int i = 0; i < 4; i++) io(0, 1, wa4[i], 32'hC0DE0000 + 32'(i));
    chk("full_count", wb_count, 4);
    io(0, 1, wa4[4], 32'hC0DE0004);
    chk("forced_count", wb_count, 4);
    chk("forced_backdoor", dut.mem_q[14'h400], 32'hC0DE0000);
    io(1, 0, 16'h1000, 32'h0);
    io(1, 0, 16'h1008, 32'h0);
    io(1, 0, 16'h100C, 32'h0);
    io(1, 0, 16'h1010, 32'h0);
    io(1, 0, 16'h1004, 32'h0);
    io(0, 1, 16'h1004, 32'h55AA55AA);
    io(1, 1, 16'h1008, 32'h77777777);
    io(1, 0, 16'h1004, 32'h0);
    chk("coal_full_count", wb_count, 4);
    idle(8);
    chk("drained_empty", wb_empty, 1);
    // Flush with reads in flight so only the flush causes draining
    io(0, 1, 16'h3000, 32'h30003000);
    io(0, 1, 16'h3004, 32'h30043004);
    io(0, 1, 16'h3008, 32'h30083008);
    chk("flush_pre_count", wb_count, 3);
    flush_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) io(1, 0, 16'h3000, 32'h0);
      else step();
      chk($sformatf("flush_count%0d", i), wb_count, cnt_exp[i]);
      chk($sformatf("flush_done%0d", i), flush_done, fd_exp[i]);
    end
    flush_req = 1'b0;
    chk("flush_bd0", dut.mem_q[14'hC00], 32'h30003000);
    chk("flush_bd1", dut.mem_q[14'hC01], 32'h30043004);
    chk("flush_bd2", dut.mem_q[14'hC02], 32'h30083008);
    step();
    flush_req = 1'b1;
    step();
    chk("flush_empty_done", flush_done, 1);
    step();
    chk("flush_empty_once", flush_done, 0);
    flush_req = 1'b0;
    idle(2);
    // Asynchronous reset with a read in flight
    io(0, 1, 16'h4000, 32'h44444444);
    io(1, 0, 16'h4000, 32'h0);
    rst_n = 1'b0;
    exp_q.delete();
    iss_q.delete();
    mdl.delete(14'h1000);
    #1;
    chk("mid_rst_valid", bus.rd_valid, 0);
    chk("mid_rst_data", bus.ram_read_data, 0);
    chk("mid_rst_count", wb_count, 0);
    chk("mid_rst_empty", wb_empty, 1);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    chk("post_rst_count", wb_count, 0);
    chk("sb_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
